// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial line, frame configuration and received-byte status bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
   logic       data_i;
   logic       parity_en_i;
   logic       parity_sel_i;
   logic       stop_sel_i;
   logic [7:0] data_o;
   logic       valid_o;
   logic       parity_err_o;
   logic       frame_err_o;
   logic       busy_o;

   modport slave (
      input  data_i, parity_en_i, parity_sel_i, stop_sel_i,
      output data_o, valid_o, parity_err_o, frame_err_o, busy_o
   );

   modport master (
      output data_i, parity_en_i, parity_sel_i, stop_sel_i,
      input  data_o, valid_o, parity_err_o, frame_err_o, busy_o
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : 8N/8E/8O UART receiver, mid-bit sampling, 1 or 2 stop bits.
//            Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
   parameter int p_clk_speed_hz = 50_000_000,
   parameter int p_baud_rate    = 9_600
) (
   input logic      clk_i,
   input logic      rst_i,
   uart_rx_if.slave bus
);

   localparam int c_cycles = p_clk_speed_hz / p_baud_rate;
   localparam int c_half   = c_cycles / 2;
   localparam int c_cnt_w  = $clog2(c_cycles) + 1;

   localparam logic [c_cnt_w-1:0] c_full_tgt = c_cnt_w'(c_cycles - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [c_cnt_w-1:0] c_start_tgt = c_cnt_w'(c_half);
`else
   localparam logic [c_cnt_w-1:0] c_start_tgt = c_cnt_w'(c_half - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [1:0]           r_sync;
   logic                 r_rxs_d;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [2:0]           r_bit_idx;
   logic                 r_stop_idx;
   logic [7:0]           r_shift;
   logic                 r_par_en;
   logic                 r_par_sel;
   logic                 r_stop2;
   logic                 r_perr_p;
   logic                 r_ferr_p;
   logic [7:0]           r_data;
   logic                 r_valid;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 w_rxs;
   logic                 w_bit;
   logic                 w_tick;
   logic                 w_done;
   logic                 w_par_exp;

   assign w_rxs     = r_sync[1];
   assign w_par_exp = r_par_sel ? ^r_shift : ~^r_shift;

`ifdef UART_RX_MAJORITY_EN
   // Decision is taken one cycle after the nominal point, so the three
   // samples straddle it: rxs(t-2), rxs(t-1), rxs(t).
   logic r_rxs_d2;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_rxs_d2 <= 1'b1;
      else       r_rxs_d2 <= r_rxs_d;
   end
   assign w_bit = (w_rxs & r_rxs_d) | (w_rxs & r_rxs_d2) | (r_rxs_d & r_rxs_d2);
`else
   assign w_bit = w_rxs;
`endif

   always_comb begin
      w_next = r_state;
      w_tick = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (r_rxs_d && !w_rxs) w_next = S_START;
         end
         S_START: begin
            if (r_cnt == c_start_tgt) begin
               w_tick = 1'b1;
               w_next = w_bit ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == c_full_tgt) begin
               w_tick = 1'b1;
               if (r_bit_idx == 3'd7) w_next = r_par_en ? S_PARITY : S_STOP;
            end
         end
         S_PARITY: begin
            if (r_cnt == c_full_tgt) begin
               w_tick = 1'b1;
               w_next = S_STOP;
            end
         end
         S_STOP: begin
            if (r_cnt == c_full_tgt) begin
               w_tick = 1'b1;
               if (!r_stop2 || r_stop_idx) begin
                  w_next = S_IDLE;
                  w_done = 1'b1;
               end
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_sync     <= 2'b11;
         r_rxs_d    <= 1'b1;
         r_cnt      <= '0;
         r_bit_idx  <= 3'd0;
         r_stop_idx <= 1'b0;
         r_shift    <= 8'h00;
         r_par_en   <= 1'b0;
         r_par_sel  <= 1'b0;
         r_stop2    <= 1'b0;
         r_perr_p   <= 1'b0;
         r_ferr_p   <= 1'b0;
         r_data     <= 8'h00;
         r_valid    <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], bus.data_i};
         r_rxs_d <= w_rxs;
         r_state <= w_next;
         r_valid <= w_done;

         if (r_state == S_IDLE || w_tick) r_cnt <= '0;
         else                             r_cnt <= r_cnt + c_cnt_one;

         case (r_state)
            S_START: begin
               // Frame format is frozen here so pin changes mid-frame are ignored.
               if (w_tick && !w_bit) begin
                  r_bit_idx  <= 3'd0;
                  r_stop_idx <= 1'b0;
                  r_perr_p   <= 1'b0;
                  r_ferr_p   <= 1'b0;
                  r_par_en   <= bus.parity_en_i;
                  r_par_sel  <= bus.parity_sel_i;
                  r_stop2    <= bus.stop_sel_i;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  r_shift   <= {w_bit, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
               end
            end
            S_PARITY: begin
               if (w_tick && (w_bit != w_par_exp)) r_perr_p <= 1'b1;
            end
            S_STOP: begin
               if (w_tick) begin
                  r_stop_idx <= 1'b1;
                  if (!w_bit) r_ferr_p <= 1'b1;
               end
            end
            default: ;
         endcase

         if (w_done) begin
            r_data <= r_shift;
            r_perr <= r_perr_p;
            r_ferr <= r_ferr_p | ~w_bit;
         end
      end
   end

   assign bus.data_o       = r_data;
   assign bus.valid_o      = r_valid;
   assign bus.parity_err_o = r_perr;
   assign bus.frame_err_o  = r_ferr;
   assign bus.busy_o       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
   localparam int c_clk_hz = 1_000_000;
   localparam int c_baud   = 100_000;
   localparam int c_c      = c_clk_hz / c_baud;
   localparam int c_h      = c_c / 2;
`ifdef UART_RX_MAJORITY_EN
   localparam int c_sh = 1;
`else
   localparam int c_sh = 0;
`endif

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         vcyc;
      int         rise;
      logic       busy;
   } cap_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   busy_rise = -1;
   logic busy_prev = 1'b0;
   cap_t cap_q[$];

   uart_rx_if bus();

   uart_rx #(.p_clk_speed_hz(c_clk_hz), .p_baud_rate(c_baud)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: every valid_o cycle is captured with its timing context.
   always @(negedge clk) begin
      cap_t e;
      if (bus.busy_o === 1'b1 && busy_prev !== 1'b1) busy_rise = cyc;
      busy_prev = bus.busy_o;
      if (bus.valid_o === 1'b1) begin
         e.d = bus.data_o; e.pe = bus.parity_err_o; e.fe = bus.frame_err_o;
         e.vcyc = cyc; e.rise = busy_rise; e.busy = bus.busy_o;
         cap_q.push_back(e);
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tx_bit(input logic b);
      bus.data_i = b;
      wait_cycles(c_c);
   endtask

   task automatic tx_frame(input logic [7:0] b, input logic pen, input logic psel, input logic pbit,
                           input logic s2, input logic st1, input logic st2v, output int t0);
      bus.parity_en_i = pen; bus.parity_sel_i = psel; bus.stop_sel_i = s2;
      t0 = cyc + 2;
      tx_bit(1'b0);
      bus.parity_en_i = 1'($urandom); bus.parity_sel_i = 1'($urandom); bus.stop_sel_i = 1'($urandom);
      for (int k = 0; k < 8; k++) tx_bit(b[k]);
      if (pen) tx_bit(pbit);
      tx_bit(st1);
      if (s2) tx_bit(st2v);
   endtask

   // Cycle in which valid_o is expected for a frame whose rxs went low at t0.
   function automatic int exp_vcyc(input int t0, input logic pen, input logic s2);
      return t0 + c_h + (9 + int'(pen) + int'(s2)) * c_c + 1 + c_sh;
   endfunction

   task automatic test_reset;
      rst = 1'b1; bus.data_i = 1'b1;
      bus.parity_en_i = 1'b0; bus.parity_sel_i = 1'b0; bus.stop_sel_i = 1'b0;
      wait_cycles(3);
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", bus.data_o); end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      checks++; if (bus.parity_err_o !== 1'b0) begin failures++; $display("FAIL reset_perr: got %b want 0", bus.parity_err_o); end
      checks++; if (bus.frame_err_o !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err_o); end
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      rst = 1'b0;
      wait_cycles(3);
      cap_q.delete();
   endtask

   task automatic test_basic;
      int t0; cap_t e;
      tx_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
      tx_bit(1'b1);
      checks++;
      if (cap_q.size() != 1) begin failures++; $display("FAIL basic_strobes: got %0d want 1", cap_q.size()); end
      else begin
         e = cap_q.pop_front();
         checks++; if (e.d !== 8'hA5) begin failures++; $display("FAIL basic_data: got %h want a5", e.d); end
         checks++; if (e.pe !== 1'b0 || e.fe !== 1'b0) begin failures++; $display("FAIL basic_errs: got pe=%b fe=%b want 0 0", e.pe, e.fe); end
         checks++; if (e.vcyc != exp_vcyc(t0, 1'b0, 1'b0)) begin failures++; $display("FAIL basic_valid_cycle: got %0d want %0d", e.vcyc, exp_vcyc(t0, 1'b0, 1'b0)); end
         checks++; if (e.rise != t0 + 1) begin failures++; $display("FAIL basic_busy_rise: got %0d want %0d", e.rise, t0 + 1); end
         checks++; if (e.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_valid: got %b want 0", e.busy); end
      end
      checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle: got %b want 0", bus.valid_o); end
      cap_q.delete();
   endtask

   task automatic test_parity;
      int t0; cap_t e;
      for (int i = 0; i < 2; i++) begin
         tx_frame(8'h07, 1'b1, 1'b1, (i == 0), 1'b0, 1'b1, 1'b1, t0);
         tx_bit(1'b1);
         checks++;
         if (cap_q.size() != 1) begin failures++; $display("FAIL parity_strobes[%0d]: got %0d want 1", i, cap_q.size()); end
         else begin
            e = cap_q.pop_front();
            checks++; if (e.d !== 8'h07) begin failures++; $display("FAIL parity_data[%0d]: got %h want 07", i, e.d); end
            checks++; if (e.pe !== (i == 1)) begin failures++; $display("FAIL parity_err[%0d]: got %b want %b", i, e.pe, (i == 1)); end
            checks++; if (e.vcyc != exp_vcyc(t0, 1'b1, 1'b0)) begin failures++; $display("FAIL parity_valid_cycle[%0d]: got %0d want %0d", i, e.vcyc, exp_vcyc(t0, 1'b1, 1'b0)); end
         end
         cap_q.delete();
      end
   endtask

   task automatic test_frame_err;
      int t0; cap_t e;
      tx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, t0);
      tx_bit(1'b1);
      checks++;
      if (cap_q.size() != 1) begin failures++; $display("FAIL ferr_strobes: got %0d want 1", cap_q.size()); end
      else begin
         e = cap_q.pop_front();
         checks++; if (e.d !== 8'h3C) begin failures++; $display("FAIL ferr_data: got %h want 3c", e.d); end
         checks++; if (e.fe !== 1'b1) begin failures++; $display("FAIL ferr_flag: got %b want 1", e.fe); end
         checks++; if (e.vcyc != exp_vcyc(t0, 1'b0, 1'b1)) begin failures++; $display("FAIL ferr_valid_cycle: got %0d want %0d", e.vcyc, exp_vcyc(t0, 1'b0, 1'b1)); end
      end
      cap_q.delete();
      tx_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
      tx_bit(1'b1);
      checks++;
      if (cap_q.size() != 1) begin failures++; $display("FAIL ferr_next_strobes: got %0d want 1", cap_q.size()); end
      else begin
         e = cap_q.pop_front();
         checks++; if (e.d !== 8'h55 || e.fe !== 1'b0) begin failures++; $display("FAIL ferr_next: got d=%h fe=%b want 55 0", e.d, e.fe); end
      end
      cap_q.delete();
   endtask

   task automatic test_glitch;
      int t0;
      bus.data_i = 1'b0;
      t0 = cyc + 2;
      wait_cycles(3);
      bus.data_i = 1'b1;
      while (cyc < t0 + 1) wait_cycles(1);
      checks++; if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL glitch_busy_high: got %b want 1", bus.busy_o); end
      while (cyc < t0 + c_h + 1 + c_sh) wait_cycles(1);
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL glitch_busy_low: got %b want 0", bus.busy_o); end
      wait_cycles(2 * c_c);
      checks++; if (cap_q.size() != 0) begin failures++; $display("FAIL glitch_no_strobe: got %0d want 0", cap_q.size()); end
      cap_q.delete();
   endtask

   task automatic test_abort;
      int t0; cap_t e;
      logic [7:0] b;
      b = 8'hC3;
      tx_bit(1'b0);
      for (int k = 0; k < 4; k++) tx_bit(b[k]);
      bus.data_i = b[4];
      wait_cycles(c_h);
      rst = 1'b1;
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", bus.busy_o); end
      checks++; if (bus.data_o !== 8'h00) begin failures++; $display("FAIL abort_data_reset: got %h want 00", bus.data_o); end
      wait_cycles(2);
      rst = 1'b0; bus.data_i = 1'b1;
      wait_cycles(3 * c_c);
      checks++; if (cap_q.size() != 0) begin failures++; $display("FAIL abort_no_strobe: got %0d want 0", cap_q.size()); end
      cap_q.delete();
      tx_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, t0);
      tx_bit(1'b1);
      checks++;
      if (cap_q.size() != 1) begin failures++; $display("FAIL abort_next_strobes: got %0d want 1", cap_q.size()); end
      else begin
         e = cap_q.pop_front();
         checks++; if (e.d !== 8'h81 || e.pe !== 1'b0 || e.fe !== 1'b0) begin failures++; $display("FAIL abort_next: got d=%h pe=%b fe=%b want 81 0 0", e.d, e.pe, e.fe); end
      end
      cap_q.delete();
   endtask

   task automatic test_back_to_back;
      int ta, tb; cap_t e;
      tx_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ta);
      tx_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, tb);
      tx_bit(1'b1);
      checks++;
      if (cap_q.size() != 2) begin failures++; $display("FAIL b2b_strobes: got %0d want 2", cap_q.size()); end
      else begin
         e = cap_q.pop_front();
         checks++; if (e.d !== 8'h00 || e.pe !== 1'b0 || e.fe !== 1'b0) begin failures++; $display("FAIL b2b_first: got d=%h pe=%b fe=%b want 00 0 0", e.d, e.pe, e.fe); end
         checks++; if (e.vcyc != exp_vcyc(ta, 1'b0, 1'b0)) begin failures++; $display("FAIL b2b_first_cycle: got %0d want %0d", e.vcyc, exp_vcyc(ta, 1'b0, 1'b0)); end
         e = cap_q.pop_front();
         checks++; if (e.d !== 8'hFF || e.pe !== 1'b0 || e.fe !== 1'b0) begin failures++; $display("FAIL b2b_second: got d=%h pe=%b fe=%b want ff 0 0", e.d, e.pe, e.fe); end
         checks++; if (e.vcyc != exp_vcyc(tb, 1'b0, 1'b0)) begin failures++; $display("FAIL b2b_second_cycle: got %0d want %0d", e.vcyc, exp_vcyc(tb, 1'b0, 1'b0)); end
      end
      cap_q.delete();
   endtask

   task automatic test_random;
      int t0; cap_t e;
      logic [7:0] b;
      logic pen, psel, pbit, s2, st1, st2v, odd, exp_pe, exp_fe;
      for (int n = 0; n < 24; n++) begin
         b    = 8'($urandom_range(0, 255));
         pen  = 1'($urandom); psel = 1'($urandom); s2 = 1'($urandom);
         odd  = ($countones(b) % 2) == 1;
         pbit = ($urandom_range(0, 3) != 0) ? (psel ? odd : !odd) : 1'($urandom);
         st1  = ($urandom_range(0, 3) != 0);
         st2v = ($urandom_range(0, 3) != 0);
         exp_pe = pen && (pbit != (psel ? odd : !odd));
         exp_fe = !st1 || (s2 && !st2v);
         tx_frame(b, pen, psel, pbit, s2, st1, st2v, t0);
         tx_bit(1'b1);
         wait_cycles($urandom_range(0, 5));
         checks++;
         if (cap_q.size() != 1) begin failures++; $display("FAIL rand_strobes[%0d]: got %0d want 1", n, cap_q.size()); end
         else begin
            e = cap_q.pop_front();
            checks++; if (e.d !== b) begin failures++; $display("FAIL rand_data[%0d]: got %h want %h", n, e.d, b); end
            checks++; if (e.pe !== exp_pe) begin failures++; $display("FAIL rand_perr[%0d]: got %b want %b", n, e.pe, exp_pe); end
            checks++; if (e.fe !== exp_fe) begin failures++; $display("FAIL rand_ferr[%0d]: got %b want %b", n, e.fe, exp_fe); end
            checks++; if (e.vcyc != exp_vcyc(t0, pen, s2)) begin failures++; $display("FAIL rand_valid_cycle[%0d]: got %0d want %0d", n, e.vcyc, exp_vcyc(t0, pen, s2)); end
         end
         cap_q.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.data_i = 1'b1;
      bus.parity_en_i = 1'b0; bus.parity_sel_i = 1'b0; bus.stop_sel_i = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_frame_err();
      test_glitch();
      test_abort();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

`default_nettype wire
